// File: rtl/snn_aer_pkg.sv
// rtl/snn_aer_pkg.sv - shared AER encoder state enum and default layer sizes
package snn_aer_pkg;

  localparam int SNN_N_NEURONS = 8;
  localparam int SNN_TS_W      = 8;

  typedef enum logic [1:0] {
    AER_IDLE  = 2'd0,
    AER_SEND  = 2'd1,
    AER_EMPTY = 2'd2
  } aer_state_e;

endpackage

// File: rtl/spike_prio_enc.sv
// rtl/spike_prio_enc.sv - lowest-set-bit priority encoder over a spike vector
module spike_prio_enc #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = $clog2(N_NEURONS)
) (
  input  logic [N_NEURONS-1:0] i_vec,
  output logic [ADDR_W-1:0]    o_idx,
  output logic                 o_one_hot_only,
  output logic                 o_any
);

  logic [N_NEURONS-1:0] w_dec;

  // Scan downward so the lowest set bit is the last assignment to stick.
  always_comb begin
    o_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = ADDR_W'(i);
    end
  end

  assign w_dec          = i_vec - N_NEURONS'(1);
  assign o_any          = |i_vec;
  assign o_one_hot_only = o_any && ((i_vec & w_dec) == '0);

endmodule

// File: rtl/aer_spike_encoder.sv
// rtl/aer_spike_encoder.sv - spike vector to AER beat serialiser; AER_EMPTY_EN adds empty-timestep beats
module aer_spike_encoder
  import snn_aer_pkg::*;
#(
  parameter int N_NEURONS = SNN_N_NEURONS,
  parameter int ADDR_W    = $clog2(N_NEURONS),
  parameter int TS_W      = SNN_TS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  input  logic [N_NEURONS-1:0] spike_vec,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic [TS_W-1:0]      aer_ts,
  output logic                 aer_last,
  output logic                 aer_empty
);

  aer_state_e           r_state;
  aer_state_e           w_state_nxt;
  logic [N_NEURONS-1:0] r_pending;
  logic [TS_W-1:0]      r_tag;
  logic [TS_W-1:0]      r_ts_cnt;

  logic [ADDR_W-1:0]    w_idx;
  logic                 w_one;
  logic                 w_any;
  logic                 w_send;
  logic                 w_empty_beat;
  logic                 w_fin;
  logic                 w_accept;
  logic [N_NEURONS-1:0] w_clr;

  spike_prio_enc #(
    .N_NEURONS (N_NEURONS),
    .ADDR_W    (ADDR_W)
  ) u_prio (
    .i_vec          (r_pending),
    .o_idx          (w_idx),
    .o_one_hot_only (w_one),
    .o_any          (w_any)
  );

  // Outputs are forced quiet while rst is high, even mid-timestep.
  always_comb begin
    w_send       = 1'b0;
    w_empty_beat = 1'b0;
    if (!rst) begin
      w_send = (r_state == AER_SEND) && w_any;
`ifdef AER_EMPTY_EN
      w_empty_beat = (r_state == AER_EMPTY);
`endif
    end
    aer_valid   = w_send || w_empty_beat;
    aer_addr    = w_send ? w_idx : '0;
    aer_ts      = aer_valid ? r_tag : '0;
    aer_last    = (w_send && w_one) || w_empty_beat;
    aer_empty   = w_empty_beat;
    w_fin       = aer_valid && aer_ready && aer_last;
    spike_ready = !rst && ((r_state == AER_IDLE) || w_fin);
    w_accept    = spike_valid && spike_ready;
    w_clr       = N_NEURONS'(1) << w_idx;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AER_IDLE: w_state_nxt = AER_IDLE;
      AER_SEND: begin
        if (w_fin || !w_any) w_state_nxt = AER_IDLE;
      end
`ifdef AER_EMPTY_EN
      AER_EMPTY: begin
        if (w_fin) w_state_nxt = AER_IDLE;
      end
`endif
      default: w_state_nxt = AER_IDLE;
    endcase
    // A new accept overrides the final handshake of the previous timestep.
    if (w_accept) begin
      if (|spike_vec) w_state_nxt = AER_SEND;
`ifdef AER_EMPTY_EN
      else            w_state_nxt = AER_EMPTY;
`else
      else            w_state_nxt = AER_IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= AER_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_tag     <= '0;
      r_ts_cnt  <= '0;
    end else if (w_accept) begin
      r_pending <= spike_vec;
      r_tag     <= r_ts_cnt;
      r_ts_cnt  <= r_ts_cnt + TS_W'(1);
    end else if (w_send && aer_ready) begin
      r_pending <= r_pending & ~w_clr;
    end
  end

endmodule
